// File: rtl/md_stall_ctrl_pkg.sv
// Shared pipeline stall definitions: stall bus layout, stall values, mul/div FSM encodings.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package md_stall_ctrl_pkg;

  // Stall bus bit order: [0]=PC, [1]=IF, [2]=ID, [3]=EX, [4]=MEM, [5]=WB.
  localparam int   StallBus = 6;
  localparam logic Stop     = 1'b1;
  localparam logic NoStop   = 1'b0;

  // Mul/div sequencing states.
  typedef enum logic [1:0] {
    MD_IDLE     = 2'd0,
    MD_MUL_WAIT = 2'd1,
    MD_DIV_WAIT = 2'd2,
    MD_COMMIT   = 2'd3
  } md_state_e;

  // PC..EX frozen while a multi-cycle op sits in EX; MEM/WB keep draining.
  localparam logic [StallBus-1:0] STALL_MD   = {{2{NoStop}}, {4{Stop}}};
  // PC..ID held for a load-use hazard; EX receives a bubble.
  localparam logic [StallBus-1:0] STALL_LOAD = {{3{NoStop}}, {3{Stop}}};
  localparam logic [StallBus-1:0] NO_STALL   = {StallBus{NoStop}};

endpackage

// File: rtl/md_stall_ctrl.sv
// Stall controller: merges load-use stalls with a start/wait/commit sequencer for mul/div in EX.
// Latency: stall/start/cancel combinational; multiply commits MUL_LAT+1 cycles after start, divide one cycle after div_done.
// Backpressure: holds PC..EX while a mul/div is outstanding; flush aborts it with a one-cycle cancel.
module md_stall_ctrl
  import md_stall_ctrl_pkg::*;
#(
  parameter int MUL_LAT     = 2,
  parameter int DIV_TIMEOUT = 64
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                flush,
  input  logic                stallreq_for_load,
  input  logic                md_req,
  input  logic                md_is_div,
  input  logic                div_done,
  output logic [StallBus-1:0] stall,
  output logic                md_start,
  output logic                md_cancel,
  output logic                md_result_valid,
  output logic                md_error,
  output logic                md_busy
);

  md_state_e  state, state_nxt;
  logic [6:0] cnt, cnt_nxt;
  // Remembers that the op reaching COMMIT was aborted, so no result is captured.
  logic       timed_out, timed_out_nxt;

  // State, counter and timeout flag registers; reset needs no cancel since the unit shares rst.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= MD_IDLE;
      cnt       <= 7'd0;
      timed_out <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      timed_out <= timed_out_nxt;
    end
  end

  // Next-state logic and combinational handshake/stall outputs.
  always_comb begin
    state_nxt       = state;
    cnt_nxt         = cnt;
    timed_out_nxt   = timed_out;
    stall           = NO_STALL;
    md_start        = 1'b0;
    md_cancel       = 1'b0;
    md_result_valid = 1'b0;
    md_error        = 1'b0;

    case (state)
      MD_IDLE: begin
        timed_out_nxt = 1'b0;
        if (md_req && !flush) begin
          // Mul/div wins over a simultaneous load-use request: EX is frozen anyway.
          md_start = 1'b1;
          stall    = STALL_MD;
          if (md_is_div) begin
            cnt_nxt   = 7'd0;
            state_nxt = MD_DIV_WAIT;
          end else begin
            cnt_nxt   = 7'(MUL_LAT - 1);
            state_nxt = MD_MUL_WAIT;
          end
        end else if (stallreq_for_load && !flush) begin
          stall = STALL_LOAD;
        end
      end

      MD_MUL_WAIT: begin
        if (flush) begin
          md_cancel = 1'b1;
          cnt_nxt   = 7'd0;
          state_nxt = MD_IDLE;
        end else begin
          stall = STALL_MD;
          if (cnt == 7'd0) state_nxt = MD_COMMIT;
          else             cnt_nxt   = cnt - 7'd1;
        end
      end

      MD_DIV_WAIT: begin
        // Flush outranks both div_done and the timeout in the same cycle.
        if (flush) begin
          md_cancel = 1'b1;
          cnt_nxt   = 7'd0;
          state_nxt = MD_IDLE;
        end else begin
          stall = STALL_MD;
          if (div_done) begin
            state_nxt = MD_COMMIT;
          end else if (cnt == 7'(DIV_TIMEOUT - 1)) begin
            md_error      = 1'b1;
            md_cancel     = 1'b1;
            timed_out_nxt = 1'b1;
            state_nxt     = MD_COMMIT;
          end else begin
            cnt_nxt = cnt + 7'd1;
          end
        end
      end

      MD_COMMIT: begin
        // EX still holds the committed instruction, so md_req is not looked at here.
        md_result_valid = !timed_out;
        cnt_nxt         = 7'd0;
        state_nxt       = MD_IDLE;
      end

      default: begin
        cnt_nxt   = 7'd0;
        state_nxt = MD_IDLE;
      end
    endcase

    // Outputs read as zero for as long as reset is held, whatever the inputs do.
    if (!rst) begin
      stall           = NO_STALL;
      md_start        = 1'b0;
      md_cancel       = 1'b0;
      md_result_valid = 1'b0;
      md_error        = 1'b0;
    end
  end

  assign md_busy = (state != MD_IDLE);

endmodule

// File: tb/tb_md_stall_ctrl.sv
// Directed bench for md_stall_ctrl with MUL_LAT=2, DIV_TIMEOUT=64.
// Latency: one vector per clock, outputs sampled 2ns after the falling edge.
// Backpressure: n/a.
module tb_md_stall_ctrl;

  localparam logic [5:0] S_MD = 6'b001111;
  localparam logic [5:0] S_LD = 6'b000111;
  localparam logic [5:0] S_0  = 6'b000000;

  logic       clk = 1'b0;
  logic       rst_n, flush, ld, req, is_div, done;
  logic [5:0] stall;
  logic       start, cancel, rvalid, err, busy;

  int n_vec = 0;
  int n_bad = 0;

  md_stall_ctrl #(.MUL_LAT(2), .DIV_TIMEOUT(64)) dut (
    .clk               (clk),
    .rst               (rst_n),
    .flush             (flush),
    .stallreq_for_load (ld),
    .md_req            (req),
    .md_is_div         (is_div),
    .div_done          (done),
    .stall             (stall),
    .md_start          (start),
    .md_cancel         (cancel),
    .md_result_valid   (rvalid),
    .md_error          (err),
    .md_busy           (busy)
  );

  always #5 clk = ~clk;

  // Expected output bundle: {stall, start, cancel, result_valid, error, busy}.
  function automatic logic [10:0] e(input logic [5:0] s, input logic st, input logic ca,
                                    input logic rv, input logic er, input logic bu);
    return {s, st, ca, rv, er, bu};
  endfunction

  typedef struct {
    logic        rst_n, flush, ld, req, is_div, done;
    logic [10:0] exp;
    string       name;
  } vec_t;

  vec_t tbl[$];

  // Drive one cycle of inputs after the falling edge, then compare the settled outputs.
  task automatic step(input logic r, input logic fl, input logic l, input logic rq,
                      input logic dv, input logic dn, input logic [10:0] exp, input string name);
    logic [10:0] act;
    @(negedge clk);
    rst_n = r; flush = fl; ld = l; req = rq; is_div = dv; done = dn;
    #2;
    act = {stall, start, cancel, rvalid, err, busy};
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got stall=%b start=%b cancel=%b rvalid=%b err=%b busy=%b, want stall=%b start=%b cancel=%b rvalid=%b err=%b busy=%b",
               name, act[10:5], act[4], act[3], act[2], act[1], act[0],
               exp[10:5], exp[4], exp[3], exp[2], exp[1], exp[0]);
    end
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; ld = 1'b0; req = 1'b0; is_div = 1'b0; done = 1'b0;

    //                rst flush ld  req div done  expected                         name
    tbl.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, e(S_0,  0,0,0,0,0), "reset_state"});
    tbl.push_back('{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, e(S_0,  0,0,0,0,0), "idle_quiet"});
    tbl.push_back('{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, e(S_LD, 0,0,0,0,0), "load_stall"});
    // Multiply at t0 together with a load request: mul/div wins.
    tbl.push_back('{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, e(S_MD, 1,0,0,0,0), "mul_start_with_load"});
    tbl.push_back('{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, e(S_MD, 0,0,0,0,1), "mul_t1"});
    tbl.push_back('{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, e(S_MD, 0,0,0,0,1), "mul_t2"});
    tbl.push_back('{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, e(S_0,  0,0,1,0,1), "mul_commit_ignores_req"});
    // Back-to-back divide starting the cycle after COMMIT.
    tbl.push_back('{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, e(S_MD, 1,0,0,0,0), "div_b2b_start"});
    tbl.push_back('{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, e(S_MD, 0,0,0,0,1), "div_wait"});
    tbl.push_back('{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, e(S_MD, 0,0,0,0,1), "div_done_cycle"});
    tbl.push_back('{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, e(S_0,  0,0,1,0,1), "div_commit"});
    tbl.push_back('{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, e(S_0,  0,0,0,0,0), "div_done_in_idle"});
    // Flush in IDLE suppresses both the start and the load stall.
    tbl.push_back('{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, e(S_0,  0,0,0,0,0), "flush_idle"});
    tbl.push_back('{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, e(S_MD, 1,0,0,0,0), "div2_start"});
    tbl.push_back('{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, e(S_MD, 0,0,0,0,1), "div2_wait"});
    tbl.push_back('{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, e(S_0,  0,1,0,0,1), "flush_beats_div_done"});
    tbl.push_back('{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, e(S_0,  0,0,0,0,0), "idle_after_div_flush"});
    tbl.push_back('{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, e(S_MD, 1,0,0,0,0), "mul2_start"});
    tbl.push_back('{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, e(S_0,  0,1,0,0,1), "flush_mul_wait"});
    tbl.push_back('{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, e(S_0,  0,0,0,0,0), "idle_after_mul_flush"});

    foreach (tbl[i])
      step(tbl[i].rst_n, tbl[i].flush, tbl[i].ld, tbl[i].req, tbl[i].is_div, tbl[i].done,
           tbl[i].exp, tbl[i].name);

    // Divide with div_done at t0+20: stalled t0..t0+20, result at t0+21.
    step(1, 0, 0, 1, 1, 0, e(S_MD, 1,0,0,0,0), "div20_start");
    for (int k = 1; k < 20; k++)
      step(1, 0, 0, 1, 1, 0, e(S_MD, 0,0,0,0,1), "div20_wait");
    step(1, 0, 0, 1, 1, 1, e(S_MD, 0,0,0,0,1), "div20_done");
    step(1, 0, 0, 1, 1, 0, e(S_0,  0,0,1,0,1), "div20_commit");
    step(1, 0, 0, 0, 0, 0, e(S_0,  0,0,0,0,0), "div20_idle");

    // Divide timeout: error+cancel at t0+64, COMMIT without result at t0+65.
    step(1, 0, 0, 1, 1, 0, e(S_MD, 1,0,0,0,0), "tmo_start");
    for (int k = 1; k < 64; k++)
      step(1, 0, 0, 1, 1, 0, e(S_MD, 0,0,0,0,1), "tmo_wait");
    step(1, 0, 0, 1, 1, 0, e(S_MD, 0,1,0,1,1), "tmo_abort");
    step(1, 0, 0, 1, 1, 0, e(S_0,  0,0,0,0,1), "tmo_commit_no_result");
    step(1, 0, 0, 0, 0, 0, e(S_0,  0,0,0,0,0), "tmo_idle");

    // Reset asserted mid-DIV_WAIT when cnt has reached 10.
    step(1, 0, 0, 1, 1, 0, e(S_MD, 1,0,0,0,0), "rst_div_start");
    for (int k = 1; k <= 10; k++)
      step(1, 0, 0, 1, 1, 0, e(S_MD, 0,0,0,0,1), "rst_div_wait");
    step(0, 0, 0, 1, 1, 0, e(S_0,  0,0,0,0,0), "rst_mid_div");
    step(0, 0, 0, 0, 0, 0, e(S_0,  0,0,0,0,0), "rst_held");
    step(1, 0, 0, 0, 0, 0, e(S_0,  0,0,0,0,0), "rst_release_idle");
    // A fresh multiply after reset must see the full latency again.
    step(1, 0, 0, 1, 0, 0, e(S_MD, 1,0,0,0,0), "post_rst_mul_start");
    step(1, 0, 0, 1, 0, 0, e(S_MD, 0,0,0,0,1), "post_rst_mul_t1");
    step(1, 0, 0, 1, 0, 0, e(S_MD, 0,0,0,0,1), "post_rst_mul_t2");
    step(1, 0, 0, 1, 0, 0, e(S_0,  0,0,1,0,1), "post_rst_mul_commit");
    step(1, 0, 0, 0, 0, 0, e(S_0,  0,0,0,0,0), "post_rst_idle");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/md_stall_ctrl.md
# md_stall_ctrl

Pipeline stall controller for the five-stage core. It sits beside the stage modules and merges two stall sources into the shared `stall` bus. The first source is the decode-stage load-use request. The second is a multi-cycle multiply/divide operation held in EX, which this block sequences through a start/wait/commit state machine. It is the only driver of `stall`. It also owns the start, cancel and result-capture handshake with the multiply/divide unit.

## Interface
- `MUL_LAT`, default 2: fixed multiplier latency in cycles, range 1..15.
- `DIV_TIMEOUT`, default 64: maximum cycles to wait for `div_done` before aborting, range 2..127.
- `clk` in 1: single clock. All state changes on the rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `flush` in 1: pipeline flush. Kills any in-flight multiply/divide.
- `stallreq_for_load` in 1: load-use hazard request from decode.
- `md_req` in 1: EX holds a mul/div instruction. Must remain high while EX is stalled.
- `md_is_div` in 1: 1 = divide, 0 = multiply. Valid with `md_req`.
- `div_done` in 1: divider result ready. Single-cycle pulse.
- `stall` out 6: `StallBus` bit order [0]=PC, [1]=IF, [2]=ID, [3]=EX, [4]=MEM, [5]=WB. 1 = `Stop`.
- `md_start` out 1: one-cycle start pulse to the mul/div unit.
- `md_cancel` out 1: one-cycle abort pulse to the mul/div unit.
- `md_result_valid` out 1: EX captures the hi/lo result this cycle.
- `md_error` out 1: one-cycle pulse on divide timeout.
- `md_busy` out 1: FSM not in IDLE.

## Operation
- States: IDLE, MUL_WAIT, DIV_WAIT, COMMIT.
- Internal 7-bit counter `cnt`.

**IDLE**
- With `md_req`=1 and `flush`=0:
  - `md_start`=1 and `stall`=6'b001111, both combinational in this same cycle.
  - Multiply: load `cnt`=MUL_LAT-1, go to MUL_WAIT.
  - Divide: load `cnt`=0, go to DIV_WAIT.
- Else, with `stallreq_for_load`=1: `stall`=6'b000111 (PC, IF, ID held; a bubble enters EX). Stay in IDLE.
- Else: `stall`=0.

**MUL_WAIT**
- `stall`=6'b001111.
- If `cnt`==0, go to COMMIT. Else `cnt`-=1.

**DIV_WAIT**
- `stall`=6'b001111.
- `div_done`=1: go to COMMIT.
- Else if `cnt`==DIV_TIMEOUT-1: pulse `md_error` and `md_cancel`, go to COMMIT.
- Else `cnt`+=1.

**COMMIT**
- `stall`=0.
- `md_result_valid`=1, except after a timeout, where it is 0.
- Go to IDLE. `md_req` is ignored this cycle, because the EX register is still the committed instruction.

**Flush and simultaneous events**
- `flush` in MUL_WAIT or DIV_WAIT: pulse `md_cancel`, `stall`=0, go to IDLE. `flush` has priority over `div_done` and over timeout.
- `flush` in IDLE: no start is issued, `stall`=0.
- `md_req` and `stallreq_for_load` together in IDLE: the multiply/divide wins. The load stall is not applied, since EX is frozen anyway.
- `div_done` outside DIV_WAIT is ignored.

**Reset**
- Reset asserted at any time, including mid-operation: the FSM goes to IDLE and `cnt`=0.
- No cancel pulse is issued on reset; the mul/div unit is reset by the same `rst`.

## Timing
- Reset value of every output is 0 (`stall`=6'b000000).
- `stall`, `md_start` and `md_cancel` are combinational from state and inputs. No registered output delay.
- Multiply from start cycle t0:
  - `stall` high for t0..t0+MUL_LAT.
  - COMMIT at t0+MUL_LAT+1.
  - Total stalled cycles = MUL_LAT+1.
- Divide with `div_done` at cycle td: COMMIT at td+1.
- Divide timeout: DIV_WAIT lasts DIV_TIMEOUT cycles, then COMMIT.
- Back-to-back mul/div: the second `md_start` comes no earlier than COMMIT+1.

## Structure
- Shared defines header holds the existing `StallBus`, `Stop` and `NoStop`.
- Add to the same header:
  - 2-bit state encodings `MD_IDLE`, `MD_MUL_WAIT`, `MD_DIV_WAIT`, `MD_COMMIT`.
  - Stall patterns `STALL_MD`=6'b001111 and `STALL_LOAD`=6'b000111.
- Single flat module. No sub-module is warranted; the counter stays inline.

## Test plan
- Reset with `rst`=0 mid-DIV_WAIT (`cnt`=10) -> all outputs 0 immediately. After release, IDLE with `md_busy`=0.
- MUL_LAT=2, `md_req`=1, `md_is_div`=0 at t0 -> `md_start` at t0 only; `stall`=6'b001111 for t0..t2; `md_result_valid` at t3; `stall`=0 at t3.
- Divide, `div_done` at t0+20 -> `stall` high for t0..t0+20, `md_result_valid` at t0+21, `md_error`=0.
- Divide with no `div_done`, DIV_TIMEOUT=64 -> `md_error` and `md_cancel` at t0+64, COMMIT at t0+65 with `md_result_valid`=0.
- `flush` at t0+5 in DIV_WAIT with `div_done` also at t0+5 -> `md_cancel`=1, `stall`=0 that cycle, IDLE at t0+6, no `md_result_valid`.
- `stallreq_for_load`=1 alone -> `stall`=6'b000111. `stallreq_for_load` and `md_req` together -> `stall`=6'b001111 with `md_start`=1.
